// File: rtl/watch_bcd_timekeeper.sv
// watch_bcd_timekeeper: 1 s prescaler plus 24 h BCD clock, set via two debounced buttons.
module watch_bcd_timekeeper #(
  parameter int TICK_DIV   = 1000,
  parameter int DEB_CYCLES = 20
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  output logic [3:0] H10,
  output logic [3:0] H1,
  output logic [3:0] M10,
  output logic [3:0] M1,
  output logic [3:0] S10,
  output logic [3:0] S1,
  output logic [1:0] SET_MODE,
  output logic       SEC_TICK
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [1:0] S_RUN = 2'b00, S_SET_H = 2'b01, S_SET_M = 2'b10, S_SET_S = 2'b11;

  logic [1:0]    w_raw, w_press;
  logic [1:0]    r_mode;
  logic [PW-1:0] r_pre;
  logic          r_tick;
  logic [3:0]    r_h10, r_h1, r_m10, r_m1, r_s10, r_s1;
  logic          w_run, w_tick, w_up;
  logic          w_s_wrap, w_m_wrap, w_h_wrap;
  logic          w_inc_s, w_inc_m, w_inc_h;

  assign w_raw = {BTN_UP, BTN_MODE};

  genvar b;
  for (b = 0; b < 2; b++) begin : g_btn
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_lvl, r_lvl_d;
    always_ff @(posedge CLK or negedge RESETN)
      if (!RESETN) begin
        r_sync  <= '0;
        r_cnt   <= '0;
        r_lvl   <= 1'b0;
        r_lvl_d <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], w_raw[b]};
        r_lvl_d <= r_lvl;
        if (r_sync[1] == r_lvl) r_cnt <= '0;
        else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_cnt <= '0;
          r_lvl <= r_sync[1];
        end else r_cnt <= r_cnt + 1'b1;
      end
    assign w_press[b] = r_lvl & ~r_lvl_d;
  end

  assign w_run    = r_mode == S_RUN;
  assign w_tick   = w_run && r_pre == PW'(TICK_DIV - 1);
  // A simultaneous MODE press wins, so UP only acts when MODE is idle.
  assign w_up     = w_press[1] & ~w_press[0] & ~w_run;
  assign w_s_wrap = r_s10 == 4'd5 && r_s1 == 4'd9;
  assign w_m_wrap = r_m10 == 4'd5 && r_m1 == 4'd9;
  assign w_h_wrap = r_h10 == 4'd2 && r_h1 == 4'd3;
  assign w_inc_s  = w_tick | (w_up && r_mode == S_SET_S);
  assign w_inc_m  = (w_tick && w_s_wrap) | (w_up && r_mode == S_SET_M);
  assign w_inc_h  = (w_tick && w_s_wrap && w_m_wrap) | (w_up && r_mode == S_SET_H);

  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      r_mode <= S_RUN;
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_h10  <= 4'd0;
      r_h1   <= 4'd0;
      r_m10  <= 4'd0;
      r_m1   <= 4'd0;
      r_s10  <= 4'd0;
      r_s1   <= 4'd0;
    end else begin
      r_tick <= w_tick;
      r_pre  <= (!w_run || w_tick) ? '0 : r_pre + 1'b1;
      if (w_press[0]) r_mode <= r_mode + 2'd1;
      if (w_inc_s) begin
        r_s1  <= r_s1 == 4'd9 ? 4'd0 : r_s1 + 4'd1;
        r_s10 <= w_s_wrap ? 4'd0 : r_s1 == 4'd9 ? r_s10 + 4'd1 : r_s10;
      end
      if (w_inc_m) begin
        r_m1  <= r_m1 == 4'd9 ? 4'd0 : r_m1 + 4'd1;
        r_m10 <= w_m_wrap ? 4'd0 : r_m1 == 4'd9 ? r_m10 + 4'd1 : r_m10;
      end
      if (w_inc_h) begin
        r_h1  <= (w_h_wrap || r_h1 == 4'd9) ? 4'd0 : r_h1 + 4'd1;
        r_h10 <= w_h_wrap ? 4'd0 : r_h1 == 4'd9 ? r_h10 + 4'd1 : r_h10;
      end
    end

  assign H10      = r_h10;
  assign H1       = r_h1;
  assign M10      = r_m10;
  assign M1       = r_m1;
  assign S10      = r_s10;
  assign S1       = r_s1;
  assign SET_MODE = r_mode;
  assign SEC_TICK = r_tick;
endmodule
